// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-loadable pattern and Mealy match flag.
// Define SEQ_CNT_EN to add a saturating match counter with synchronous clear.
module seq_detect_param #(
    parameter int unsigned          PAT_W   = 4,
    parameter logic [PAT_W-1:0]     PAT_RST = PAT_W'(4'b1011),
    parameter bit                   OVERLAP = 1'b1,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             In,
    input  logic             in_valid,
    input  logic             pat_ld,
    input  logic [PAT_W-1:0] pat_in,
    output logic             out
`ifdef SEQ_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt,
    input  logic             cnt_clr
`endif
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  r_hist;
    logic [PAT_W-1:0]  r_pat;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]  w_window;
    logic              w_full;

    // Match is decided on fill alone so an all-zero pattern still needs PAT_W real bits.
    assign w_window = {r_hist[PAT_W-2:0], In};
    assign w_full   = (r_fill >= FILL_W'(PAT_W - 1));
    assign out      = in_valid & ~pat_ld & w_full & (w_window == r_pat);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= PAT_RST;
        end else if (pat_ld) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= pat_in;
        end else if (in_valid) begin
            r_hist <= w_window;
            if (out && !OVERLAP) begin
                r_fill <= '0;
            end else if (r_fill != FILL_W'(PAT_W)) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

`ifdef SEQ_CNT_EN
    logic [CNT_W-1:0] r_match_cnt;

    // Clear beats a simultaneous match; the count saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_match_cnt <= '0;
        end else if (cnt_clr) begin
            r_match_cnt <= '0;
        end else if (out && (r_match_cnt != {CNT_W{1'b1}})) begin
            r_match_cnt <= r_match_cnt + CNT_W'(1);
        end
    end

    assign match_cnt = r_match_cnt;
`endif

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- PAT_RST, 4'b1011, pattern value loaded at reset; PAT_W bits wide.
- OVERLAP, 1, 1 = overlapping detection, 0 = non-overlapping detection.
- CNT_W, 8, width of the match counter.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- In, input, 1, serial data bit; sampled only when in_valid=1.
- in_valid, input, 1, qualifies In this cycle.
- pat_ld, input, 1, loads pat_in into the pattern register.
- pat_in, input, PAT_W, new pattern; MSB is the first bit received.
- out, output, 1, Mealy match flag.
- match_cnt, output, CNT_W, number of matches; present only under SEQ_CNT_EN.
- cnt_clr, input, 1, synchronous clear of match_cnt; present only under SEQ_CNT_EN.

Function
REQ-003 The block SHALL hold a history register hist[PAT_W-1:0], a fill counter fill (0..PAT_W, saturating) and a pattern register pat[PAT_W-1:0].
REQ-004 out SHALL be combinational (Mealy): out = in_valid & ~pat_ld & (fill >= PAT_W-1) & ({hist[PAT_W-2:0], In} == pat).
REQ-005 out SHALL assert in the same cycle as the last pattern bit, with zero latency.
REQ-006 On a rising edge with in_valid=1 and pat_ld=0, hist SHALL shift left and take In as its LSB.
REQ-007 On the same edge, fill SHALL increment, saturating at PAT_W.
REQ-008 In the cycle where out=1 with OVERLAP=1, hist and fill SHALL update as in REQ-006/REQ-007; the matched bits remain usable as a prefix of the next match.
REQ-009 In the cycle where out=1 with OVERLAP=0, fill SHALL be set to 0 and hist shifts normally; no bit of the matched sequence contributes to the next match.
REQ-010 With in_valid=0, hist and fill SHALL hold, and out SHALL be 0.
REQ-011 With pat_ld=1, pat SHALL load pat_in, fill SHALL clear to 0, hist SHALL clear to 0, and out SHALL be 0.
REQ-012 When pat_ld=1 and in_valid=1 occur together, pat_ld SHALL take priority and the In bit of that cycle SHALL be discarded.
REQ-013 A pattern of all-zeros SHALL be legal; detection SHALL depend only on fill, not on hist contents.
REQ-014 Under SEQ_CNT_EN, match_cnt SHALL increment by 1 on every edge where out=1.
REQ-015 Under SEQ_CNT_EN, match_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-016 Under SEQ_CNT_EN, cnt_clr=1 SHALL set match_cnt to 0 on the next edge; cnt_clr SHALL win over a simultaneous match, and out still asserts in that cycle.

Reset
REQ-017 On rst=0, asynchronously: hist=0, fill=0, pat=PAT_RST, and (under SEQ_CNT_EN) match_cnt=0.
REQ-018 While rst=0, out SHALL be 0 regardless of In and in_valid.
REQ-019 Reset asserted mid-sequence SHALL discard the partial match; after release, a full PAT_W bits SHALL be required before out can assert.
REQ-020 Reset deassertion SHALL take effect at the first rising edge of clk after rst returns high.

Configuration
REQ-021 When macro SEQ_CNT_EN is defined, the ports match_cnt and cnt_clr and the counter logic SHALL be present.
REQ-022 When SEQ_CNT_EN is undefined, those ports and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-023 The bench SHALL cover these directed scenarios (defaults, pattern 1011, OVERLAP=1), one per line:
- Stream 1,0,1,1,0,1,1 with in_valid=1 -> out=1 on bits 4 and 7 only.
- OVERLAP=0, same stream 1,0,1,1,0,1,1 -> out=1 on bit 4 only.
- OVERLAP=0, pattern 1111 loaded, stream of eight 1s -> out=1 on bits 4 and 8.
- Stream 1,0,1 then in_valid=0 for 3 cycles, then 1 -> out=1 on the final bit only, and out=0 during the gap.
- pat_ld with pat_in=0110 together with in_valid=1, then stream 0,1,1,0 -> out=1 on the 4th bit; the bit presented in the load cycle is ignored.
- Under SEQ_CNT_EN with CNT_W=2: 5 matches -> match_cnt=3 (saturated); rst=0 mid-stream -> all state 0, out=0, and a partial match is lost.
